// File: rtl/mod_event_counter_if.sv
// Handshake bundle for mod_event_counter: event/control inputs and count/flag outputs.
interface mod_event_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             x;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_flag;
  logic [WIDTH-1:0] out;
  logic             z;
  logic             tc;

  modport master (
    output en, x, up, load, load_val, clr_flag,
    input  out, z, tc
  );

  modport slave (
    input  en, x, up, load, load_val, clr_flag,
    output out, z, tc
  );
endinterface

// File: rtl/mod_event_counter.sv
// Modulo up/down event counter with saturating parallel load, sticky wrap flag z
// and a one-cycle terminal-count pulse tc.
module mod_event_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int EDGE_MODE = 0
) (
  input  logic                clock,
  input  logic                reset,
  mod_event_counter_if.slave  bus
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("mod_event_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt, cnt_nxt, load_clamped;
  logic             x_d, ev, wrap, z_r, tc_r;

  assign ev = bus.en & bus.x & ((EDGE_MODE != 0) ? ~x_d : 1'b1);

  // Load takes the cycle, so a coincident event never wraps.
  assign wrap = ev & ~bus.load & (bus.up ? (cnt == MAX) : (cnt == '0));

  assign load_clamped = (bus.load_val > MAX) ? MAX : bus.load_val;

  always_comb begin
    cnt_nxt = cnt;
    if (bus.load)       cnt_nxt = load_clamped;
    else if (ev) begin
      if (bus.up)       cnt_nxt = (cnt == MAX) ? '0 : cnt + WIDTH'(1);
      else              cnt_nxt = (cnt == '0) ? MAX : cnt - WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    // Edge history tracks x even in reset, so x held high across release is not an edge.
    x_d <= bus.x;
    if (reset) begin
      cnt  <= '0;
      z_r  <= 1'b0;
      tc_r <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tc_r <= wrap;
      if (wrap)              z_r <= 1'b1;
      else if (bus.clr_flag) z_r <= 1'b0;
    end
  end

  assign bus.out = cnt;
  assign bus.z   = z_r;
  assign bus.tc  = tc_r;

endmodule
